// File: rtl/tpu_core.sv
// tpu_core: 4x4 outer-product int8 matrix-multiply engine over external synchronous buffers.
// Optional build macro TPU_SATURATE_EN clamps each result lane to [-128, 127] instead of wrapping.
module tpu_core #(
  parameter int ARRAY      = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = ARRAY * DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  output logic                  valid_o,
  input  logic [ADDR_WIDTH-1:0] m_i,
  input  logic [ADDR_WIDTH-1:0] k_i,
  input  logic [ADDR_WIDTH-1:0] n_i,
  input  logic [ADDR_WIDTH-1:0] base_addra_i,
  input  logic [ADDR_WIDTH-1:0] base_addrb_i,
  input  logic [ADDR_WIDTH-1:0] base_addrp_i,
  output logic                  ena_o,
  output logic                  wea_o,
  output logic [ADDR_WIDTH-1:0] addra_o,
  input  logic [WORD_WIDTH-1:0] worda_i,
  output logic                  enb_o,
  output logic                  web_o,
  output logic [ADDR_WIDTH-1:0] addrb_o,
  input  logic [WORD_WIDTH-1:0] wordb_i,
  output logic                  enp_o,
  output logic                  wep_o,
  output logic [ADDR_WIDTH-1:0] addrp_o,
  output logic [WORD_WIDTH-1:0] wordp_o
);

  localparam int LG = $clog2(ARRAY);
  localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);
  localparam logic [LG-1:0] LAST_ROW = LG'(ARRAY - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAIN, S_WRITE, S_NEXT, S_DONE} state_t;

  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] k_q, k_d, mbn_q, mbn_d, nbn_q, nbn_d, base_b_q, base_b_d;
  logic [ADDR_WIDTH-1:0] a_row_q, a_row_d, b_col_q, b_col_d, p_ptr_q, p_ptr_d;
  logic [ADDR_WIDTH-1:0] kk_q, kk_d, mb_q, mb_d, nb_q, nb_d;
  logic [LG-1:0]         row_q, row_d;
  logic                  acc_en_q;
  logic                  acc_clr;
  logic [ADDR_WIDTH-1:0] mb_count, nb_count;
  logic [ARRAY*WORD_WIDTH-1:0] conv_all;
  logic [WORD_WIDTH-1:0] row_word;

  assign mb_count = (m_i >> LG) + ADDR_WIDTH'(|m_i[LG-1:0]);
  assign nb_count = (n_i >> LG) + ADDR_WIDTH'(|n_i[LG-1:0]);
  assign row_word = conv_all[int'(row_q)*WORD_WIDTH +: WORD_WIDTH];
  assign acc_clr  = (state_d == S_LOAD) && (state_q != S_LOAD);
  assign wea_o    = 1'b0;
  assign web_o    = 1'b0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      k_q      <= '0;
      mbn_q    <= '0;
      nbn_q    <= '0;
      base_b_q <= '0;
      a_row_q  <= '0;
      b_col_q  <= '0;
      p_ptr_q  <= '0;
      kk_q     <= '0;
      mb_q     <= '0;
      nb_q     <= '0;
      row_q    <= '0;
      acc_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      mbn_q    <= mbn_d;
      nbn_q    <= nbn_d;
      base_b_q <= base_b_d;
      a_row_q  <= a_row_d;
      b_col_q  <= b_col_d;
      p_ptr_q  <= p_ptr_d;
      kk_q     <= kk_d;
      mb_q     <= mb_d;
      nb_q     <= nb_d;
      row_q    <= row_d;
      // read data arrives one cycle after the LOAD address, so accumulate a cycle late
      acc_en_q <= (state_q == S_LOAD);
    end
  end

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    mbn_d    = mbn_q;
    nbn_d    = nbn_q;
    base_b_d = base_b_q;
    a_row_d  = a_row_q;
    b_col_d  = b_col_q;
    p_ptr_d  = p_ptr_q;
    kk_d     = kk_q;
    mb_d     = mb_q;
    nb_d     = nb_q;
    row_d    = row_q;
    valid_o  = 1'b0;
    ena_o    = 1'b0;
    enb_o    = 1'b0;
    addra_o  = '0;
    addrb_o  = '0;
    enp_o    = 1'b0;
    wep_o    = 1'b0;
    addrp_o  = '0;
    wordp_o  = '0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          k_d      = k_i;
          mbn_d    = mb_count;
          nbn_d    = nb_count;
          base_b_d = base_addrb_i;
          a_row_d  = base_addra_i;
          b_col_d  = base_addrb_i;
          p_ptr_d  = base_addrp_i;
          kk_d     = '0;
          mb_d     = '0;
          nb_d     = '0;
          if (m_i == '0 || k_i == '0 || n_i == '0) state_d = S_DONE;
          else                                     state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        ena_o   = 1'b1;
        enb_o   = 1'b1;
        addra_o = a_row_q + kk_q;
        addrb_o = b_col_q + kk_q;
        if (kk_q == k_q - ONE) begin
          kk_d    = '0;
          state_d = S_DRAIN;
        end else begin
          kk_d = kk_q + ONE;
        end
      end
      S_DRAIN: begin
        row_d   = '0;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        enp_o   = 1'b1;
        wep_o   = 1'b1;
        addrp_o = p_ptr_q;
        wordp_o = row_word;
        p_ptr_d = p_ptr_q + ONE;
        row_d   = row_q + LG'(1);
        if (row_q == LAST_ROW) state_d = S_NEXT;
      end
      S_NEXT: begin
        // P rows are contiguous across tiles, so p_ptr simply keeps counting
        if (nb_q + ONE == nbn_q) begin
          nb_d    = '0;
          b_col_d = base_b_q;
          a_row_d = a_row_q + k_q;
          if (mb_q + ONE == mbn_q) begin
            state_d = S_DONE;
          end else begin
            mb_d    = mb_q + ONE;
            state_d = S_LOAD;
          end
        end else begin
          nb_d    = nb_q + ONE;
          b_col_d = b_col_q + k_q;
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        valid_o = 1'b1;
        if (!start_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  for (genvar gi = 0; gi < ARRAY; gi++) begin : g_row
    for (genvar gj = 0; gj < ARRAY; gj++) begin : g_col
      logic signed [DATA_WIDTH-1:0]   a_el, b_el;
      logic signed [2*DATA_WIDTH-1:0] prod;
      logic signed [ACC_WIDTH-1:0]    acc_q;
      assign a_el = worda_i[gi*DATA_WIDTH +: DATA_WIDTH];
      assign b_el = wordb_i[gj*DATA_WIDTH +: DATA_WIDTH];
      assign prod = a_el * b_el;

      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)         acc_q <= '0;
        else if (acc_clr)  acc_q <= '0;
        else if (acc_en_q) acc_q <= acc_q + {{(ACC_WIDTH-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
      end

`ifdef TPU_SATURATE_EN
      localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'((1 << (DATA_WIDTH-1)) - 1);
      localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = -ACC_WIDTH'(1 << (DATA_WIDTH-1));
      always_comb begin
        if (acc_q > SAT_MAX)
          conv_all[(gi*ARRAY+gj)*DATA_WIDTH +: DATA_WIDTH] = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else if (acc_q < SAT_MIN)
          conv_all[(gi*ARRAY+gj)*DATA_WIDTH +: DATA_WIDTH] = {1'b1, {(DATA_WIDTH-1){1'b0}}};
        else
          conv_all[(gi*ARRAY+gj)*DATA_WIDTH +: DATA_WIDTH] = acc_q[DATA_WIDTH-1:0];
      end
`else
      assign conv_all[(gi*ARRAY+gj)*DATA_WIDTH +: DATA_WIDTH] = acc_q[DATA_WIDTH-1:0];
`endif
    end
  end

endmodule

// File: tb/tb_tpu_core.sv
// Randomized self-checking bench for tpu_core: buffer models, golden matrix product, per-cycle port checker.
module tb_tpu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_i = 1'b0;
  logic        valid_o;
  logic [15:0] m_i = '0, k_i = '0, n_i = '0;
  logic [15:0] base_addra_i = '0, base_addrb_i = '0, base_addrp_i = '0;
  logic        ena_o, wea_o, enb_o, web_o, enp_o, wep_o;
  logic [15:0] addra_o, addrb_o, addrp_o;
  logic [31:0] worda_i = '0, wordb_i = '0, wordp_o;

  always #5 clk = ~clk;

  tpu_core dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .valid_o(valid_o),
    .m_i(m_i), .k_i(k_i), .n_i(n_i),
    .base_addra_i(base_addra_i), .base_addrb_i(base_addrb_i), .base_addrp_i(base_addrp_i),
    .ena_o(ena_o), .wea_o(wea_o), .addra_o(addra_o), .worda_i(worda_i),
    .enb_o(enb_o), .web_o(web_o), .addrb_o(addrb_o), .wordb_i(wordb_i),
    .enp_o(enp_o), .wep_o(wep_o), .addrp_o(addrp_o), .wordp_o(wordp_o)
  );

  logic [31:0] mem_a [256];
  logic [31:0] mem_b [256];
  logic [31:0] mem_p [256];

  always @(posedge clk) begin
    if (ena_o) worda_i <= mem_a[addra_o[7:0]];
    if (enb_o) wordb_i <= mem_b[addrb_o[7:0]];
    if (enp_o && wep_o) mem_p[addrp_o[7:0]] <= wordp_o;
  end

  int checks = 0;
  int errors = 0;
  int amat [16][16];
  int bmat [16][16];
  logic [15:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];
  int a_reads = 0;
  int cur_ba = 0, cur_bb = 0, cur_mbn = 0, cur_nbn = 0, cur_k = 0;

  function automatic logic [7:0] conv(int v);
    logic [31:0] t;
`ifdef TPU_SATURATE_EN
    if (v > 127) return 8'h7F;
    if (v < -128) return 8'h80;
`endif
    t = v;
    return t[7:0];
  endfunction

  // Compare process: buffer-port legality and every P write against the golden queue.
  always @(negedge clk) begin
    if (ena_o) a_reads++;
    if (ena_o || enb_o || wea_o || web_o) begin
      checks++;
      if (!(ena_o && enb_o && !wea_o && !web_o &&
            int'(addra_o) >= cur_ba && int'(addra_o) < cur_ba + cur_mbn*cur_k &&
            int'(addrb_o) >= cur_bb && int'(addrb_o) < cur_bb + cur_nbn*cur_k)) begin
        errors++;
        $display("FAIL rd_port: ena=%0b enb=%0b wea=%0b web=%0b addra=%0d addrb=%0d", ena_o, enb_o, wea_o, web_o, addra_o, addrb_o);
      end
    end
    if (enp_o || wep_o) begin
      checks++;
      if (!(enp_o && wep_o) || exp_addr_q.size() == 0) begin
        errors++;
        $display("FAIL p_write: enp=%0b wep=%0b addr=%0d, expected writes pending=%0d", enp_o, wep_o, addrp_o, exp_addr_q.size());
      end else begin
        logic [15:0] ea;
        logic [31:0] ed;
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        if (addrp_o !== ea || wordp_o !== ed) begin
          errors++;
          $display("FAIL p_write: got addr=%h data=%h, required addr=%h data=%h", addrp_o, wordp_o, ea, ed);
        end
      end
    end
  end

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic check_outputs_zero(string name);
    check(name, {valid_o, ena_o, wea_o, enb_o, web_o, enp_o, wep_o, addra_o, addrb_o},
          64'd0);
    check({name, "_p"}, {addrp_o, wordp_o}, 64'd0);
  endtask

  task automatic clear_mats();
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) begin
        amat[i][j] = 0;
        bmat[i][j] = 0;
      end
  endtask

  task automatic rand_mats(int m, int k, int n);
    clear_mats();
    for (int i = 0; i < m; i++)
      for (int j = 0; j < k; j++) amat[i][j] = int'($urandom_range(255)) - 128;
    for (int i = 0; i < k; i++)
      for (int j = 0; j < n; j++) bmat[i][j] = int'($urandom_range(255)) - 128;
  endtask

  task automatic build_expected(int m, int k, int n, int bp);
    int mbn, nbn, sum;
    logic [31:0] w;
    exp_addr_q.delete();
    exp_data_q.delete();
    if (m == 0 || k == 0 || n == 0) return;
    mbn = (m + 3) / 4;
    nbn = (n + 3) / 4;
    for (int mb = 0; mb < mbn; mb++)
      for (int nb = 0; nb < nbn; nb++)
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 4; c++) begin
            sum = 0;
            for (int kk = 0; kk < k; kk++) sum += amat[4*mb+r][kk] * bmat[kk][4*nb+c];
            w[8*c +: 8] = conv(sum);
          end
          exp_addr_q.push_back(16'(bp + (mb*nbn + nb)*4 + r));
          exp_data_q.push_back(w);
        end
  endtask

  // Called at #1 after a rising edge; returns at the same phase.
  task automatic run(int m, int k, int n, int ba, int bb, int bp, bit do_reset);
    int mbn, nbn, cyc, a0, exp_cyc, exp_reads;
    logic [31:0] w;
    mbn = (m + 3) / 4;
    nbn = (n + 3) / 4;
    for (int mb = 0; mb < mbn; mb++)
      for (int kk = 0; kk < k; kk++) begin
        for (int r = 0; r < 4; r++) w[8*r +: 8] = 8'(amat[4*mb+r][kk]);
        mem_a[8'(ba + mb*k + kk)] = w;
      end
    for (int nb = 0; nb < nbn; nb++)
      for (int kk = 0; kk < k; kk++) begin
        for (int c = 0; c < 4; c++) w[8*c +: 8] = 8'(bmat[kk][4*nb+c]);
        mem_b[8'(bb + nb*k + kk)] = w;
      end
    build_expected(m, k, n, bp);
    cur_ba = ba; cur_bb = bb; cur_mbn = mbn; cur_nbn = nbn; cur_k = k;
    m_i = 16'(m); k_i = 16'(k); n_i = 16'(n);
    base_addra_i = 16'(ba); base_addrb_i = 16'(bb); base_addrp_i = 16'(bp);
    a0 = a_reads;
    start_i = 1'b1;
    if (do_reset) begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      #1 check_outputs_zero("reset_mid_load");
      build_expected(m, k, n, bp);
      a0 = a_reads;
      @(posedge clk);
      #1 rst = 1'b0;
    end
    cyc = 0;
    do begin
      @(posedge clk);
      cyc++;
      #1;
      if (cyc == 1) begin
        m_i = 16'($urandom); k_i = 16'($urandom); n_i = 16'($urandom);
        base_addra_i = 16'($urandom); base_addrb_i = 16'($urandom); base_addrp_i = 16'($urandom);
      end
    end while (!valid_o && cyc < 3000);
    exp_cyc   = (m == 0 || k == 0 || n == 0) ? 0 : mbn*nbn*(k + 6);
    exp_reads = (m == 0 || k == 0 || n == 0) ? 0 : mbn*nbn*k;
    check("valid_reached", 64'(valid_o), 64'd1);
    check("latency", 64'(cyc - 1), 64'(exp_cyc));
    check("p_writes_left", 64'(exp_addr_q.size()), 64'd0);
    check("a_read_count", 64'(a_reads - a0), 64'(exp_reads));
    @(posedge clk);
    #1 check("valid_hold", 64'(valid_o), 64'd1);
    start_i = 1'b0;
    @(posedge clk);
    #1 check("valid_clear", 64'(valid_o), 64'd0);
    $display("run m=%0d k=%0d n=%0d ba=%0d bb=%0d bp=%0d rst=%0b cycles=%0d errors=%0d",
             m, k, n, ba, bb, bp, do_reset, cyc - 1, errors);
  endtask

  initial begin
    logic [31:0] id_exp [4];
    logic [31:0] ovf_exp;
    id_exp[0] = 32'h04030201; id_exp[1] = 32'h05040302;
    id_exp[2] = 32'h06050403; id_exp[3] = 32'h07060504;
`ifdef TPU_SATURATE_EN
    ovf_exp = 32'h7F7F7F7F;
`else
    ovf_exp = 32'h04040404;
`endif
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end

    repeat (2) @(posedge clk);
    #1 check_outputs_zero("reset_state");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // identity: P must equal B
    clear_mats();
    for (int i = 0; i < 4; i++) amat[i][i] = 1;
    for (int kk = 0; kk < 4; kk++)
      for (int c = 0; c < 4; c++) bmat[kk][c] = kk + 1 + c;
    run(4, 4, 4, 0, 0, 0, 1'b0);
    for (int r = 0; r < 4; r++) check("identity_row", 64'(mem_p[r]), 64'(id_exp[r]));

    // negative operands
    clear_mats();
    for (int r = 0; r < 4; r++) amat[r][0] = -1;
    for (int c = 0; c < 4; c++) bmat[0][c] = c + 2;
    run(4, 1, 4, 8, 16, 32, 1'b0);
    for (int r = 0; r < 4; r++) check("negative_row", 64'(mem_p[32+r]), 64'h00000000FBFCFDFE);

    // overflow: 4 * 127 * 127 = 64516
    clear_mats();
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        amat[i][j] = 127;
        bmat[i][j] = 127;
      end
    run(4, 4, 4, 40, 50, 48, 1'b0);
    for (int r = 0; r < 4; r++) check("overflow_row", 64'(mem_p[48+r]), 64'(ovf_exp));

    // multi-tile
    rand_mats(8, 2, 8);
    run(8, 2, 8, 0, 64, 32, 1'b0);

    // zero dimension: no buffer traffic, immediate valid
    clear_mats();
    run(4, 0, 4, 0, 0, 0, 1'b0);

    // reset during LOAD, start held through release
    rand_mats(6, 5, 7);
    run(6, 5, 7, 10, 80, 128, 1'b1);

    for (int t = 0; t < 10; t++) begin
      int m, k, n;
      m = int'($urandom_range(1, 9));
      k = int'($urandom_range(1, 9));
      n = int'($urandom_range(1, 9));
      rand_mats(m, k, n);
      run(m, k, n, int'($urandom_range(0, 40)), int'($urandom_range(64, 100)),
          int'($urandom_range(128, 180)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
